// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline front end and the hazard controller.
// The controller takes the slave modport; the pipeline datapath drives the master side.
interface pipeline_hazard_ctrl_if #(
   parameter int STALL_CNT_W = 16
);
   logic [4:0]             id_rs_i;
   logic [4:0]             id_rt_i;
   logic                   id_uses_rt_i;
   logic                   id_reads_hilo_i;
   logic                   ex_mem_read_i;
   logic [4:0]             ex_rt_i;
   logic                   ex_md_start_i;
   logic                   branch_taken_i;
   logic                   pc_stall_o;
   logic                   ifid_stall_o;
   logic                   ifid_flush_o;
   logic                   idex_flush_o;
   logic                   md_busy_o;
   logic                   md_done_o;
   logic                   err_o;
   logic [STALL_CNT_W-1:0] stall_cnt_o;

   modport master (
      output id_rs_i, id_rt_i, id_uses_rt_i, id_reads_hilo_i,
             ex_mem_read_i, ex_rt_i, ex_md_start_i, branch_taken_i,
      input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_flush_o,
             md_busy_o, md_done_o, err_o, stall_cnt_o
   );

   modport slave (
      input  id_rs_i, id_rt_i, id_uses_rt_i, id_reads_hilo_i,
             ex_mem_read_i, ex_rt_i, ex_md_start_i, branch_taken_i,
      output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_flush_o,
             md_busy_o, md_done_o, err_o, stall_cnt_o
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard controller: load-use / MULT-DIV stalls and taken-branch flushes.
// Controls are combinational (zero latency); MD interlock is a small counter FSM.
module pipeline_hazard_ctrl #(
   parameter int MD_LATENCY  = 4,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   pipeline_hazard_ctrl_if.slave  bus
);

   typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [7:0]             cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic lu_hzd, mh_hzd, br, stall, md_done;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      md_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.ex_md_start_i) begin
               state_d = MD_BUSY;
               cnt_d   = 8'(MD_LATENCY - 1);
            end
         end
         MD_BUSY: begin
            // A second issue while busy is dropped; the running op keeps its count.
            if (bus.ex_md_start_i) err_d = 1'b1;
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               md_done = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign lu_hzd = bus.ex_mem_read_i && (bus.ex_rt_i != 5'd0) &&
                   ((bus.ex_rt_i == bus.id_rs_i) ||
                    (bus.id_uses_rt_i && (bus.ex_rt_i == bus.id_rt_i)));
   assign mh_hzd = (state_q == MD_BUSY) && bus.id_reads_hilo_i;
   assign br     = bus.branch_taken_i;

   // A taken branch discards the ID instruction, so stalling for it is pointless.
   assign stall = reset && !br && (lu_hzd || mh_hzd);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
   end

   assign bus.pc_stall_o   = stall;
   assign bus.ifid_stall_o = stall;
   assign bus.ifid_flush_o = reset && br;
   assign bus.idex_flush_o = reset && (br || lu_hzd || mh_hzd);
   assign bus.md_busy_o    = reset && (state_q == MD_BUSY);
   assign bus.md_done_o    = reset && md_done;
   assign bus.err_o        = err_q;
   assign bus.stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MD_LATENCY=4 and a narrow 8-bit stall counter.
module tb_pipeline_hazard_ctrl;

   localparam int MD_LAT = 4;
   localparam int SCW    = 8;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   pipeline_hazard_ctrl_if #(.STALL_CNT_W(SCW)) bus ();

   pipeline_hazard_ctrl #(.MD_LATENCY(MD_LAT), .STALL_CNT_W(SCW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.id_rs_i = 5'd0;        bus.id_rt_i = 5'd0;
      bus.id_uses_rt_i = 1'b0;   bus.id_reads_hilo_i = 1'b0;
      bus.ex_mem_read_i = 1'b0;  bus.ex_rt_i = 5'd0;
      bus.ex_md_start_i = 1'b0;  bus.branch_taken_i = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      clr();
      // Hazard inputs asserted during reset must not reach the controls
      bus.ex_mem_read_i = 1'b1; bus.ex_rt_i = 5'd8; bus.id_rs_i = 5'd8; bus.branch_taken_i = 1'b1;
      #2;
      chk("rst_pc_stall", 32'(bus.pc_stall_o), 0);
      chk("rst_ifid_flush", 32'(bus.ifid_flush_o), 0);
      chk("rst_idex_flush", 32'(bus.idex_flush_o), 0);
      tick(); tick();
      clr();
      reset = 1'b1;
      #1;
      chk("rst_stall_cnt", 32'(bus.stall_cnt_o), 0);
      chk("rst_err", 32'(bus.err_o), 0);
      chk("rst_busy", 32'(bus.md_busy_o), 0);

      // 1: load-use on rs
      bus.ex_mem_read_i = 1'b1; bus.ex_rt_i = 5'd8; bus.id_rs_i = 5'd8;
      #1;
      chk("lu_pc_stall", 32'(bus.pc_stall_o), 1);
      chk("lu_ifid_stall", 32'(bus.ifid_stall_o), 1);
      chk("lu_idex_flush", 32'(bus.idex_flush_o), 1);
      chk("lu_ifid_flush", 32'(bus.ifid_flush_o), 0);
      tick();
      clr();
      #1;
      chk("lu_next_no_stall", 32'(bus.pc_stall_o), 0);
      chk("lu_stall_cnt", 32'(bus.stall_cnt_o), 1);

      // 2: r0 never hazards; rt only when used
      bus.ex_mem_read_i = 1'b1; bus.ex_rt_i = 5'd0; bus.id_rs_i = 5'd0;
      #1;
      chk("r0_no_stall", 32'(bus.pc_stall_o), 0);
      chk("r0_no_flush", 32'(bus.idex_flush_o), 0);
      bus.ex_rt_i = 5'd9; bus.id_rt_i = 5'd9; bus.id_rs_i = 5'd3; bus.id_uses_rt_i = 1'b0;
      #1;
      chk("rt_unused_no_stall", 32'(bus.pc_stall_o), 0);
      bus.id_uses_rt_i = 1'b1;
      #1;
      chk("rt_used_stall", 32'(bus.pc_stall_o), 1);
      tick();
      clr();
      #1;
      chk("rt_stall_cnt", 32'(bus.stall_cnt_o), 2);

      // 3: MD interlock, start at c0, HI/LO reader waiting c0..c4
      bus.ex_md_start_i = 1'b1; bus.id_reads_hilo_i = 1'b1;
      #1;
      chk("md_c0_busy", 32'(bus.md_busy_o), 0);
      chk("md_c0_stall", 32'(bus.pc_stall_o), 0);
      tick();
      bus.ex_md_start_i = 1'b0;
      #1;
      chk("md_c1_busy", 32'(bus.md_busy_o), 1);
      chk("md_c1_stall", 32'(bus.pc_stall_o), 1);
      chk("md_c1_done", 32'(bus.md_done_o), 0);
      tick();
      chk("md_c2_busy", 32'(bus.md_busy_o), 1);
      chk("md_c2_stall", 32'(bus.pc_stall_o), 1);
      chk("md_c2_done", 32'(bus.md_done_o), 0);
      tick();
      chk("md_c3_busy", 32'(bus.md_busy_o), 1);
      chk("md_c3_stall", 32'(bus.pc_stall_o), 1);
      chk("md_c3_done", 32'(bus.md_done_o), 1);
      tick();
      chk("md_c4_busy", 32'(bus.md_busy_o), 0);
      chk("md_c4_stall", 32'(bus.pc_stall_o), 0);
      chk("md_c4_done", 32'(bus.md_done_o), 0);
      chk("md_stall_cnt", 32'(bus.stall_cnt_o), 5);
      clr();

      // 4: branch overrides load-use
      bus.ex_mem_read_i = 1'b1; bus.ex_rt_i = 5'd8; bus.id_rs_i = 5'd8; bus.branch_taken_i = 1'b1;
      #1;
      chk("br_ifid_flush", 32'(bus.ifid_flush_o), 1);
      chk("br_idex_flush", 32'(bus.idex_flush_o), 1);
      chk("br_pc_stall", 32'(bus.pc_stall_o), 0);
      chk("br_ifid_stall", 32'(bus.ifid_stall_o), 0);
      tick();
      clr();
      #1;
      chk("br_stall_cnt", 32'(bus.stall_cnt_o), 5);

      // 5: illegal restart while busy; a branch does not abort MD
      bus.ex_md_start_i = 1'b1;
      tick();
      bus.ex_md_start_i = 1'b0; bus.branch_taken_i = 1'b1;
      #1;
      chk("err_c1_br_flush", 32'(bus.ifid_flush_o), 1);
      tick();
      bus.branch_taken_i = 1'b0; bus.ex_md_start_i = 1'b1;
      #1;
      chk("err_c2_busy", 32'(bus.md_busy_o), 1);
      chk("err_c2_err", 32'(bus.err_o), 0);
      tick();
      bus.ex_md_start_i = 1'b0;
      #1;
      chk("err_c3_err", 32'(bus.err_o), 1);
      chk("err_c3_done", 32'(bus.md_done_o), 1);
      tick();
      chk("err_c4_busy", 32'(bus.md_busy_o), 0);
      chk("err_c4_err", 32'(bus.err_o), 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk("err_cleared", 32'(bus.err_o), 0);
      chk("cnt_cleared", 32'(bus.stall_cnt_o), 0);

      // 6: saturation after 2^SCW+2 stall cycles, then reset mid-busy
      bus.ex_mem_read_i = 1'b1; bus.ex_rt_i = 5'd8; bus.id_rs_i = 5'd8;
      for (int i = 0; i < (1 << SCW) + 2; i++) tick();
      chk("sat_stall_cnt", 32'(bus.stall_cnt_o), 32'((1 << SCW) - 1));
      clr();
      bus.ex_md_start_i = 1'b1;
      tick();
      bus.ex_md_start_i = 1'b0;
      #1;
      chk("rb_busy_before", 32'(bus.md_busy_o), 1);
      reset = 1'b0;
      #1;
      chk("rb_busy_forced", 32'(bus.md_busy_o), 0);
      tick();
      reset = 1'b1;
      #1;
      chk("rb_idle_busy", 32'(bus.md_busy_o), 0);
      chk("rb_idle_done", 32'(bus.md_done_o), 0);
      tick();
      chk("rb_later_busy", 32'(bus.md_busy_o), 0);
      chk("rb_later_done", 32'(bus.md_done_o), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
